// File: rtl/opll_pkg.sv
// Shared constants, channel register layout and slot helpers for the OPLL core.
package opll_pkg;

  localparam int NUM_CH   = 9;
  localparam int NUM_SLOT = 18;

  localparam logic [7:0] ADDR_USER = 8'h00;
  localparam logic [7:0] ADDR_RHY  = 8'h0E;
  localparam logic [7:0] ADDR_FLO  = 8'h10;
  localparam logic [7:0] ADDR_FHI  = 8'h20;
  localparam logic [7:0] ADDR_IV   = 8'h30;

  typedef struct packed {
    logic [8:0] fnum;
    logic [2:0] blk;
    logic       kon;
    logic       sus;
    logic [3:0] inst;
    logic [3:0] vol;
    logic [3:0] rvol;
  } ch_regs_t;

  // Two operator slots per channel: modulator (even) then carrier (odd).
  function automatic logic [3:0] slot_to_ch(input logic [4:0] s);
    return s[4:1];
  endfunction

endpackage

// File: rtl/opll_cpu_latch.sv
// CPU-side address latch and single-entry pending write holder.
// Runs on every clk regardless of the core clock enable.
module opll_cpu_latch (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_wr,
  input  logic       cpu_a0,
  input  logic [7:0] cpu_d,
  input  logic       commit,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  logic [7:0] addr_latch;

  // A data write arriving in the commit clk re-arms pending, so it is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_latch <= 8'h00;
      wr_addr    <= 8'h00;
      wr_data    <= 8'h00;
      busy       <= 1'b0;
    end else begin
      if (cpu_wr && !cpu_a0) addr_latch <= cpu_d;
      if (cpu_wr && cpu_a0) begin
        wr_data <= cpu_d;
        wr_addr <= addr_latch;
        busy    <= 1'b1;
      end else if (commit) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/opll_slot_regfile.sv
// OPLL register file: commits CPU writes in WR_STAGE and registers the
// current slot's parameters in FETCH_STAGE for the operator pipeline.
module opll_slot_regfile
  import opll_pkg::*;
#(
  parameter int WR_STAGE    = 3,
  parameter int FETCH_STAGE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clkena,
  input  logic [4:0]  slot,
  input  logic [1:0]  stage,
  input  logic        cpu_wr,
  input  logic        cpu_a0,
  input  logic [7:0]  cpu_d,
  output logic        busy,
  output logic [8:0]  fnum,
  output logic [2:0]  blk,
  output logic        kon,
  output logic        sus,
  output logic [3:0]  inst,
  output logic [3:0]  vol,
  output logic        rhythm,
  output logic [4:0]  rkon,
  output logic [63:0] user_inst,
  output logic        is_car
);

  logic       commit;
  logic       fetch;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       chan_ok;
  ch_regs_t   regs [NUM_CH];
  logic [7:0] user_regs [8];
  logic [5:0] rhy_reg;

  logic [3:0] ch;
  logic       slot_ok;
  ch_regs_t   cur;
  logic [3:0] next_vol;

  assign commit  = clkena && (stage == WR_STAGE[1:0]) && busy;
  assign fetch   = clkena && (stage == FETCH_STAGE[1:0]);
  assign chan_ok = (wr_addr[3:0] < 4'(NUM_CH));

  opll_cpu_latch u_cpu_latch (
    .clk     (clk),
    .reset   (reset),
    .cpu_wr  (cpu_wr),
    .cpu_a0  (cpu_a0),
    .cpu_d   (cpu_d),
    .commit  (commit),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy)
  );

  // Register array update; unmapped addresses simply drop the pending write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) regs[i] <= '0;
      for (int i = 0; i < 8; i++) user_regs[i] <= 8'h00;
      rhy_reg <= 6'h00;
    end else if (commit) begin
      case (wr_addr[7:4])
        ADDR_USER[7:4]: begin
          if (!wr_addr[3]) user_regs[wr_addr[2:0]] <= wr_data;
          else if (wr_addr == ADDR_RHY) rhy_reg <= wr_data[5:0];
        end
        ADDR_FLO[7:4]: if (chan_ok) regs[wr_addr[3:0]].fnum[7:0] <= wr_data;
        ADDR_FHI[7:4]: begin
          if (chan_ok) begin
            regs[wr_addr[3:0]].sus     <= wr_data[5];
            regs[wr_addr[3:0]].kon     <= wr_data[4];
            regs[wr_addr[3:0]].blk     <= wr_data[3:1];
            regs[wr_addr[3:0]].fnum[8] <= wr_data[0];
          end
        end
        ADDR_IV[7:4]: begin
          if (chan_ok) begin
            regs[wr_addr[3:0]].inst <= wr_data[7:4];
            regs[wr_addr[3:0]].vol  <= wr_data[3:0];
            regs[wr_addr[3:0]].rvol <= wr_data[7:4];
          end
        end
        default: ;
      endcase
    end
  end

  // Channel lookup and volume select; HH/TOM modulators take the upper nibble in rhythm mode.
  always_comb begin
    ch       = slot_to_ch(slot);
    slot_ok  = (slot < 5'(NUM_SLOT));
    cur      = '0;
    next_vol = 4'h0;
    if (slot_ok) cur = regs[ch];
    else cur = '0;
    if (!slot_ok) next_vol = 4'h0;
    else if (slot[0]) next_vol = cur.vol;
    else if (rhy_reg[5] && (ch == 4'd7 || ch == 4'd8)) next_vol = cur.rvol;
    else next_vol = 4'h0;
  end

  // Fetched outputs hold for the remainder of the slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fnum   <= 9'h000;
      blk    <= 3'h0;
      kon    <= 1'b0;
      sus    <= 1'b0;
      inst   <= 4'h0;
      vol    <= 4'h0;
      is_car <= 1'b0;
      rhythm <= 1'b0;
      rkon   <= 5'h00;
    end else if (fetch) begin
      fnum   <= cur.fnum;
      blk    <= cur.blk;
      kon    <= cur.kon;
      sus    <= cur.sus;
      inst   <= cur.inst;
      vol    <= next_vol;
      is_car <= slot_ok & slot[0];
      rhythm <= rhy_reg[5];
      rkon   <= rhy_reg[4:0];
    end
  end

  // Flatten the user instrument bytes.
  always_comb begin
    user_inst = 64'h0;
    for (int i = 0; i < 8; i++) user_inst[8*i +: 8] = user_regs[i];
  end

endmodule

// File: tb/tb_opll_slot_regfile.sv
// Directed bench for opll_slot_regfile; the bench models the slot counter itself.
module tb_opll_slot_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        clkena;
  logic [4:0]  slot;
  logic [1:0]  stage;
  logic        cpu_wr;
  logic        cpu_a0;
  logic [7:0]  cpu_d;
  logic        busy;
  logic [8:0]  fnum;
  logic [2:0]  blk;
  logic        kon;
  logic        sus;
  logic [3:0]  inst;
  logic [3:0]  vol;
  logic        rhythm;
  logic [4:0]  rkon;
  logic [63:0] user_inst;
  logic        is_car;

  int          vectors = 0;
  int          miscompares = 0;
  logic [1:0]  prev_stage = 2'd0;
  logic [28:0] snap [18];
  logic [28:0] held;

  opll_slot_regfile #(.WR_STAGE(3), .FETCH_STAGE(0)) dut (
    .clk(clk), .reset(reset), .clkena(clkena), .slot(slot), .stage(stage),
    .cpu_wr(cpu_wr), .cpu_a0(cpu_a0), .cpu_d(cpu_d), .busy(busy),
    .fnum(fnum), .blk(blk), .kon(kon), .sus(sus), .inst(inst), .vol(vol),
    .rhythm(rhythm), .rkon(rkon), .user_inst(user_inst), .is_car(is_car)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [28:0] out_word();
    return {fnum, blk, kon, sus, inst, vol, is_car, rhythm, rkon};
  endfunction

  // One clock; the slot counter model advances only with clkena.
  task automatic step();
    @(posedge clk);
    #1;
    prev_stage = stage;
    if (clkena && !reset) begin
      if (stage == 2'd3) begin
        stage = 2'd0;
        slot  = (slot == 5'd17) ? 5'd0 : slot + 5'd1;
      end else begin
        stage = stage + 2'd1;
      end
    end
  endtask

  // Returns with outputs holding the fetched parameters of slot s.
  task automatic goto_fetch(input logic [4:0] s);
    int n = 0;
    while (!(slot == s && stage == 2'd0) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check_vec("fetch_timeout", 64'(n), 64'd0);
    step();
  endtask

  task automatic cpu_write(input logic a0, input logic [7:0] d);
    cpu_wr = 1'b1;
    cpu_a0 = a0;
    cpu_d  = d;
    step();
    cpu_wr = 1'b0;
  endtask

  task automatic wait_commit(input string tag);
    int n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    check_vec({tag, "_busy_clear"}, 64'(busy), 64'd0);
    check_vec({tag, "_commit_stage"}, 64'(prev_stage), 64'd3);
  endtask

  task automatic reg_write(input string tag, input logic [7:0] a, input logic [7:0] d);
    cpu_write(1'b0, a);
    cpu_write(1'b1, d);
    check_vec({tag, "_busy_set"}, 64'(busy), 64'd1);
    wait_commit(tag);
  endtask

  initial begin
    reset = 1'b1; clkena = 1'b1; slot = 5'd0; stage = 2'd0;
    cpu_wr = 1'b0; cpu_a0 = 1'b0; cpu_d = 8'h00;
    #12;
    check_vec("rst_outputs", 64'(out_word()), 64'd0);
    check_vec("rst_user", user_inst, 64'h0);
    check_vec("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int s = 0; s < 18; s++) begin
      goto_fetch(5'(s));
      check_vec("rst_slot_fnum_kon", 64'({fnum, kon}), 64'd0);
    end

    // Channel 3 frequency/key registers.
    reg_write("ch3_flo", 8'h13, 8'hA5);
    reg_write("ch3_fhi", 8'h23, 8'h1D);
    goto_fetch(5'd6);
    check_vec("s6_fnum", 64'(fnum), 64'h1A5);
    check_vec("s6_blk", 64'(blk), 64'd6);
    check_vec("s6_kon_sus_car", 64'({kon, sus, is_car}), 64'b100);
    goto_fetch(5'd7);
    check_vec("s7_fnum", 64'(fnum), 64'h1A5);
    check_vec("s7_blk_kon_sus_car", 64'({blk, kon, sus, is_car}), 64'b110_1_0_1);

    // Rhythm mode volume routing on channel 7 (HH).
    reg_write("ch7_iv", 8'h37, 8'h5C);
    reg_write("rhy_on", 8'h0E, 8'h35);
    goto_fetch(5'd14);
    check_vec("s14_hh_vol", 64'(vol), 64'h5);
    check_vec("s14_rhy", 64'({rhythm, rkon, is_car}), 64'({1'b1, 5'h15, 1'b0}));
    check_vec("s14_inst", 64'(inst), 64'h5);
    goto_fetch(5'd15);
    check_vec("s15_car_vol", 64'({vol, is_car}), 64'({4'hC, 1'b1}));
    reg_write("rhy_off", 8'h0E, 8'h00);
    goto_fetch(5'd14);
    check_vec("s14_mod_vol", 64'({vol, rhythm, rkon}), 64'd0);

    // Data write landing in the same clk as the earlier write's commit.
    begin
      int n = 0;
      while (stage != 2'd0 && n < 8) begin step(); n++; end
    end
    cpu_write(1'b0, 8'h31);
    cpu_write(1'b1, 8'h47);
    cpu_write(1'b0, 8'h32);
    check_vec("coll_stage", 64'(stage), 64'd3);
    cpu_write(1'b1, 8'h96);
    check_vec("coll_busy_still", 64'(busy), 64'd1);
    wait_commit("coll_second");
    goto_fetch(5'd3);
    check_vec("coll_first", 64'({inst, vol, is_car}), 64'({4'h4, 4'h7, 1'b1}));
    goto_fetch(5'd5);
    check_vec("coll_second", 64'({inst, vol, is_car}), 64'({4'h9, 4'h6, 1'b1}));

    // Unmapped channel offset: pending clears, nothing changes.
    for (int s = 0; s < 18; s++) begin
      goto_fetch(5'(s));
      snap[s] = out_word();
    end
    reg_write("ign", 8'h19, 8'hFF);
    for (int s = 0; s < 18; s++) begin
      goto_fetch(5'(s));
      check_vec("ign_unchanged", 64'(out_word()), 64'(snap[s]));
    end

    // Clock enable low: write stays pending, outputs frozen.
    cpu_write(1'b0, 8'h33);
    goto_fetch(5'd7);
    held = out_word();
    clkena = 1'b0;
    cpu_write(1'b1, 8'h2A);
    for (int i = 0; i < 20; i++) begin
      check_vec("gate_busy", 64'(busy), 64'd1);
      check_vec("gate_hold", 64'(out_word()), 64'(held));
      step();
    end
    clkena = 1'b1;
    wait_commit("gate");
    goto_fetch(5'd7);
    check_vec("gate_iv", 64'({inst, vol, fnum}), 64'({4'h2, 4'hA, 9'h1A5}));

    // User instrument bytes are visible without fetch latency.
    reg_write("user2", 8'h02, 8'h33);
    check_vec("user2", user_inst, 64'h0000_0000_0033_0000);
    reg_write("user7", 8'h07, 8'hC1);
    check_vec("user7", user_inst, 64'hC100_0000_0033_0000);

    // Reset with a write pending.
    cpu_write(1'b0, 8'h14);
    cpu_write(1'b1, 8'h77);
    check_vec("mid_busy_set", 64'(busy), 64'd1);
    reset = 1'b1;
    #2;
    check_vec("mid_rst_outputs", 64'(out_word()), 64'd0);
    check_vec("mid_rst_user", user_inst, 64'h0);
    check_vec("mid_rst_busy", 64'(busy), 64'd0);
    slot = 5'd0;
    stage = 2'd0;
    @(negedge clk);
    reset = 1'b0;
    goto_fetch(5'd8);
    check_vec("mid_discard", 64'({fnum, busy}), 64'd0);
    goto_fetch(5'd7);
    check_vec("mid_cleared", 64'({fnum, kon, inst, vol}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/opll_slot_regfile.md
Name: opll_slot_regfile

Overview:
- FM core register file for the OPLL engine; consumer of the slot counter's slot/stage outputs.
- Accepts CPU address/data writes (YM2413-style two-port) into channel and user-instrument registers.
- At each slot boundary, fetches and registers that slot's parameters for the phase and envelope stages.
- Sits between the bus interface and the per-slot operator pipeline.

Parameters:
- WR_STAGE, 3, stage value (0-3) in which a pending CPU write is committed to the register array.
- FETCH_STAGE, 0, stage value in which slot parameters are read and registered onto the outputs; must differ from WR_STAGE.

Ports:
- clk  in  1  system clock
- reset  in  1  async active-high reset
- clkena  in  1  core clock enable; all state advances only when high, except CPU capture
- slot  in  5  current slot 0-17 from slot counter
- stage  in  2  current stage 0-3 from slot counter
- cpu_wr  in  1  one-clk write strobe (independent of clkena)
- cpu_a0  in  1  0 = address write, 1 = data write
- cpu_d  in  8  write data
- busy  out  1  data write pending, not yet committed
- fnum  out  9  F-number of the slot's channel
- blk  out  3  block/octave
- kon  out  1  key-on
- sus  out  1  sustain flag
- inst  out  4  instrument number (0 = user)
- vol  out  4  volume nibble for this slot
- rhythm  out  1  rhythm mode bit ($0E bit 5)
- rkon  out  5  rhythm key bits ($0E bits 4:0)
- user_inst  out  64  user instrument bytes $00-$07, byte n at [8n+7:8n]
- is_car  out  1  slot is carrier (slot[0])

Behaviour:
- Decided: reset is named reset, asynchronous, active-high; clock is clk.
- Reset state:
  - address latch 0; pending flag 0; busy 0.
  - All registers 0; every output 0.
- CPU capture (any clk, ignores clkena):
  - cpu_wr with a0=0: address latch <= cpu_d.
  - cpu_wr with a0=1: pending data <= cpu_d, pending addr <= latch, pending flag <= 1.
  - A second data write while pending overwrites the pending data/addr (last wins); it is not queued.
- Commit:
  - Occurs on clkena && stage==WR_STAGE && pending.
  - Writes the register array and clears pending; busy = pending flag.
  - cpu_wr data in the same clk as the commit: the new write wins and pending stays 1.
- Address decode:
  - $00-$07 user instrument; $0E rhythm.
  - $10-$18 fnum[7:0]; $20-$28 {sus, kon, blk, fnum[8]} from bits 5,4,3:1,0.
  - $30-$38 {inst, vol} from bits 7:4, 3:0.
  - Channel offsets 9-F and all other addresses are ignored; pending still clears.
- Fetch:
  - Occurs on clkena && stage==FETCH_STAGE; ch = slot[4:1].
  - fnum, blk, kon, sus, inst, is_car, rhythm and rkon are registered from ch.
  - Outputs are valid from the next clk and hold for the rest of the slot (stages 1-3). Latency: one clk after the fetch enable.
- Volume select:
  - Carrier: vol = $3x[3:0].
  - Modulator in rhythm mode, ch 7 (HH) or ch 8 (TOM): vol = $3x[7:4].
  - Otherwise modulator vol = 0.
- slot > 17 (should not occur): all channel outputs registered as 0.
- Write/read ordering: a commit in WR_STAGE of slot n is visible at the fetch of slot n+1. Reads and writes never share a cycle, so there is no read-during-write hazard.
- user_inst is continuous from the registers (no fetch latency).
- Reset mid-operation: pending write discarded, all registers cleared immediately.
- clkena low: outputs, array and pending hold; CPU capture continues.

Decomposition:
- Shared package opll_pkg holds:
  - NUM_CH=9, NUM_SLOT=18.
  - Address constants ADDR_USER, ADDR_RHY, ADDR_FLO, ADDR_FHI, ADDR_IV.
  - Typedef ch_regs_t {fnum, blk, kon, sus, inst, vol, rvol}.
  - Function slot_to_ch.
- One sub-module: opll_cpu_latch (address latch, pending holding register, busy).
- Array and fetch stay in the top module.

Test Plan:
- Reset: assert reset mid-run -> all outputs 0, busy 0; after release with no writes, fnum=0 and kon=0 for all 18 slots.
- Channel write: addr $13, data $A5; addr $23, data $1D; then wait for slot 6 fetch -> fnum=$1A5, blk=6, kon=1, sus=0 on slots 6 and 7. busy high from data write until the first WR_STAGE with clkena, then 0.
- Volume/rhythm: $37 <= $5C, $0E <= $20 -> slot 14 vol=5 (HH), slot 15 vol=C, rhythm=1. After $0E <= $00, slot 14 vol=0.
- Collision: data write issued in the same clk as the commit of an earlier write -> first committed, second still pending with busy=1, committed at the next WR_STAGE.
- Ignored address: addr $19 data $FF -> busy clears at commit, no output changes on any slot.
- clkena gating: hold clkena low 20 clks after a data write -> busy stays 1, outputs frozen. Commit occurs only after clkena returns.
